// File: rtl/display_scan_ctrl_if.sv
// rtl/display_scan_ctrl_if.sv - write port bundle for the display scan sequencer
interface display_scan_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  wr_en;
  logic [DIGITS*4-1:0]   wr_data;
  logic [DIGITS-1:0]     wr_dp;
  logic                  wr_ready;

  modport master (output wr_en, output wr_data, output wr_dp, input wr_ready);
  modport slave  (input wr_en, input wr_data, input wr_dp, output wr_ready);
endinterface

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - multiplexed 7-segment scan sequencer with frame-synchronous shadow buffer
module display_scan_ctrl #(
  parameter int          DIGITS      = 4,
  parameter int          ON_TICKS    = 3,
  parameter int          BLANK_TICKS = 1,
  parameter logic [23:0] P0          = 24'd12499,
  parameter logic [23:0] P1          = 24'd24999,
  parameter logic [23:0] P2          = 24'd49999,
  parameter logic [23:0] P3          = 24'd99999
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [1:0]        rate_sel,
  output logic [23:0]       tmr_period,
  display_scan_ctrl_if.slave wr,
  output logic [DIGITS-1:0] anode,
  output logic [6:0]        seg,
  output logic              dp,
  output logic              frame_start
);
  localparam int CMAX = (ON_TICKS > BLANK_TICKS) ? ON_TICKS : BLANK_TICKS;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {BLANK, SHOW} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                boundary, commit, pending;
  logic [DIGITS*4-1:0] shadow_data, active_data, active_data_d;
  logic [DIGITS-1:0]   shadow_dp, active_dp, active_dp_d;
  logic [3:0]          nibble_d;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    boundary = 1'b0;
    if (tick) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end else if (state_q == SHOW) begin
        state_d = BLANK;
        cnt_d   = CW'(BLANK_TICKS - 1);
      end else begin
        state_d = SHOW;
        cnt_d   = CW'(ON_TICKS - 1);
        if (idx_q == IW'(DIGITS - 1)) begin
          idx_d    = '0;
          boundary = 1'b1;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
    end
    // Outputs are registered from the post-edge view, so a commit on this edge is already visible on digit 0.
    commit        = boundary && pending;
    active_data_d = commit ? shadow_data : active_data;
    active_dp_d   = commit ? shadow_dp : active_dp;
    nibble_d      = active_data_d[idx_d*4 +: 4];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BLANK;
      idx_q   <= IW'(DIGITS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending     <= 1'b0;
      shadow_data <= '0;
      shadow_dp   <= '0;
      active_data <= '0;
      active_dp   <= '0;
      tmr_period  <= P0;
      frame_start <= 1'b0;
      anode       <= '1;
      seg         <= 7'h7F;
      dp          <= 1'b1;
    end else begin
      frame_start <= boundary;
      if (boundary) begin
        case (rate_sel)
          2'd0:    tmr_period <= P0;
          2'd1:    tmr_period <= P1;
          2'd2:    tmr_period <= P2;
          default: tmr_period <= P3;
        endcase
      end
      if (commit) begin
        active_data <= shadow_data;
        active_dp   <= shadow_dp;
        pending     <= 1'b0;
      end else if (wr.wr_en && !pending) begin
        shadow_data <= wr.wr_data;
        shadow_dp   <= wr.wr_dp;
        pending     <= 1'b1;
      end
      if (state_d == SHOW) begin
        anode <= ~(DIGITS'(1) << idx_d);
        seg   <= hex7(nibble_d);
        dp    <= ~active_dp_d[idx_d];
      end else begin
        anode <= '1;
        seg   <= 7'h7F;
        dp    <= 1'b1;
      end
    end
  end

  assign wr.wr_ready = ~pending;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - scoreboard bench for display_scan_ctrl
module tb_display_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic [1:0]  rate_sel = 2'd0;
  logic [23:0] tmr_period;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  display_scan_ctrl_if #(.DIGITS(4)) wr_if ();

  display_scan_ctrl #(.DIGITS(4)) dut (
    .clk(clk), .rst(rst), .tick(tick), .rate_sel(rate_sel), .tmr_period(tmr_period),
    .wr(wr_if), .anode(anode), .seg(seg), .dp(dp), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dp;
    logic        fs;
    logic        ready;
    logic [23:0] period;
  } exp_t;

  exp_t sb[$];
  int n_assert = 0;
  int n_fail = 0;

  logic [6:0]  seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  logic [23:0] per_tab [4] = '{24'd12499, 24'd24999, 24'd49999, 24'd99999};

  // Position model: 16 ticks per frame, each digit slot is 3 lit ticks then 1 blank tick
  int          m_pos;
  logic        m_pend, m_fs;
  logic [15:0] m_act_d, m_sh_d;
  logic [3:0]  m_act_p, m_sh_p;
  logic [23:0] m_period;

  task automatic model_reset();
    m_pos = 15; m_pend = 1'b0; m_fs = 1'b0;
    m_act_d = '0; m_sh_d = '0; m_act_p = '0; m_sh_p = '0;
    m_period = per_tab[0];
  endtask

  function automatic exp_t model_out();
    exp_t       e;
    int         digit = m_pos / 4;
    logic [3:0] one = 4'b0001;
    if (m_pos % 4 < 3) begin
      e.anode = ~(one << digit);
      e.seg   = seg_tab[m_act_d[digit*4 +: 4]];
      e.dp    = ~m_act_p[digit];
    end else begin
      e.anode = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
    end
    e.fs = m_fs; e.ready = ~m_pend; e.period = m_period;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_front();
    exp_t e = sb.pop_front();
    chk("anode", 24'(anode), 24'(e.anode));
    chk("seg", 24'(seg), 24'(e.seg));
    chk("dp", 24'(dp), 24'(e.dp));
    chk("frame_start", 24'(frame_start), 24'(e.fs));
    chk("wr_ready", 24'(wr_if.wr_ready), 24'(e.ready));
    chk("tmr_period", tmr_period, e.period);
  endtask

  task automatic step(input bit t, input bit w, input logic [15:0] d, input logic [3:0] p);
    @(negedge clk);
    tick = t; wr_if.wr_en = w; wr_if.wr_data = d; wr_if.wr_dp = p;
    m_fs = 1'b0;
    if (t) begin
      m_pos = (m_pos + 1) % 16;
      if (m_pos == 0) begin
        m_fs = 1'b1;
        if (m_pend) begin m_act_d = m_sh_d; m_act_p = m_sh_p; m_pend = 1'b0; end
        m_period = per_tab[rate_sel];
      end
    end
    if (w && !m_pend) begin m_sh_d = d; m_sh_p = p; m_pend = 1'b1; end
    sb.push_back(model_out());
    @(negedge clk);
    tick = 1'b0; wr_if.wr_en = 1'b0;
    check_front();
  endtask

  task automatic tick_slots(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 16'h0, 4'h0);
      step(1'b0, 1'b0, 16'h0, 4'h0);
    end
  endtask

  task automatic reset_check();
    #1;
    model_reset();
    sb.push_back(model_out());
    check_front();
  endtask

  initial begin
    wr_if.wr_en = 1'b0; wr_if.wr_data = '0; wr_if.wr_dp = '0;
    repeat (2) @(negedge clk);
    reset_check();
    @(negedge clk); rst = 1'b1;

    tick_slots(16);

    tick_slots(5);
    step(1'b0, 1'b1, 16'h1A8F, 4'b0100);
    step(1'b0, 1'b1, 16'h2222, 4'b1111);
    tick_slots(11);
    tick_slots(16);

    tick_slots(6);
    rate_sel = 2'd2;
    tick_slots(26);

    for (int i = 0; i < 16 && m_pos != 15; i++) tick_slots(1);
    step(1'b1, 1'b1, 16'h7C35, 4'b1001);
    step(1'b0, 1'b0, 16'h0, 4'h0);
    tick_slots(32);

    step(1'b0, 1'b1, 16'hBEEF, 4'b1111);
    tick_slots(1);
    for (int i = 0; i < 4 && m_pos % 4 == 3; i++) tick_slots(1);
    @(negedge clk);
    #2 rst = 1'b0;
    reset_check();
    @(negedge clk); rst = 1'b1;
    tick_slots(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Sequencer for the board's 4-digit multiplexed 7-segment display, driven by the periodic tick of a companion timer instance.
- Supplies the timer's 24-bit period from a scan-rate select and scans the digits one at a time, with a blanking slot between digits to suppress ghosting.
- Accepts new display contents through a ready/valid write port. Writes go to a shadow buffer that is committed only at a frame boundary, so a frame never shows mixed old and new data.

Parameters:
- DIGITS, 4, number of digits scanned. Width of anode/wr_dp and DIGITS*4 width of wr_data.
- ON_TICKS, 3, ticks a digit is lit per slot (≥1).
- BLANK_TICKS, 1, ticks all anodes are off after each digit (≥1).
- P0, 24'd12499, tmr_period for rate_sel=0.
- P1, 24'd24999, tmr_period for rate_sel=1.
- P2, 24'd49999, tmr_period for rate_sel=2.
- P3, 24'd99999, tmr_period for rate_sel=3.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- tick  in  1  one-clock pulse from the timer flag output
- rate_sel  in  2  scan-rate select, sampled at frame boundary
- tmr_period  out  24  period driven into the timer
- wr_en  in  1  write request
- wr_data  in  DIGITS*4  hex nibbles; digit0 = [3:0]
- wr_dp  in  DIGITS  decimal point per digit, 1 = lit
- wr_ready  out  1  shadow buffer free
- anode  out  DIGITS  active-low digit enables
- seg  out  7  active-low {g,f,e,d,c,b,a}
- dp  out  1  active-low decimal point
- frame_start  out  1  one-clock pulse when digit 0 begins

Behaviour:
- All outputs are registered and update on the clk edge after the tick that causes the event, i.e. 1-cycle latency from tick.
- Reset values:
  - anode all 1, seg 7'h7F, dp 1, frame_start 0, wr_ready 1, tmr_period = P0.
  - Active and shadow buffers = 0, pending = 0.
  - State BLANK, idx = DIGITS-1, cnt = 0.
- States:
  - SHOW: anode[idx] = 0, others 1; seg/dp decode active nibble idx.
  - BLANK: anode all 1, seg 7'h7F, dp 1.
- Transitions. Non-tick cycles hold state and counters.
  - SHOW, tick, cnt ≠ 0: cnt − 1.
  - SHOW, tick, cnt = 0: go to BLANK, cnt = BLANK_TICKS−1.
  - BLANK, tick, cnt ≠ 0: cnt − 1.
  - BLANK, tick, cnt = 0: go to SHOW, idx = (idx == DIGITS−1) ? 0 : idx+1, cnt = ON_TICKS−1.
- Frame boundary is the BLANK→SHOW transition with wrap to idx 0. On that edge:
  - frame_start = 1 for one clock.
  - If pending: active ← shadow, pending ← 0.
  - tmr_period ← P[rate_sel].
- rate_sel changes mid-frame are ignored until the next boundary. Because the timer reloads through a two-stage pipeline, a new period affects tick spacing up to two ticks later; this is acceptable.
- Write handshake:
  - wr_ready = ~pending.
  - wr_en && wr_ready: shadow ← {wr_data, wr_dp}, pending ← 1 on the same edge.
  - wr_en while wr_ready = 0: ignored, no data captured.
  - A write accepted on the frame-boundary edge is not committed on that edge; it commits at the following boundary.
  - Commit and a new write can never coincide, since wr_ready = 0 while pending.
- Hex decode, active-low, seg = {g,f,e,d,c,b,a}:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- dp = ~active_dp[idx] in SHOW.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronously). Pending shadow data is discarded.
- First tick after reset is a frame boundary and lights digit 0 with active = 0.

Test Plan:
- Reset then tick every 4 clks: first tick gives frame_start pulse, anode=1110, seg=1000000. Digit 0 lit for 3 ticks, then anode=1111 for 1 tick, then anode=1101. Anode sequence repeats 1110,1111,1101,1111,1011,1111,0111,1111.
- Write wr_data=16'h1A8F, wr_dp=4'b0100 mid-frame: wr_ready drops next clk. Display stays 0 until the next frame_start. Then digit0 seg=0001110, digit1 seg=0000000, digit2 seg=0001000 with dp=0, digit3 seg=1111001. wr_ready returns to 1 on the commit edge.
- Second wr_en while pending (data 16'h2222): ignored. The next frame shows the first write.
- rate_sel=2 mid-frame: tmr_period stays P0 until the frame_start edge, then becomes 24'd49999.
- wr_en asserted on the exact frame-boundary edge: accepted, but the new data appears one frame later.
- rst pulsed low mid-SHOW with pending=1: outputs go to reset values immediately. After release, digit 0 shows 0 and wr_ready=1.
